bitcoin_mem_responder: RTL and testbench
========================================

# bitcoin_mem_responder

Synthesizable memory-side partner for the `bitcoin_hash` core. It answers the core's word-addressed memory interface, writes the 19-word header from a seed before starting the core, and runs the start/done handshake. After completion it streams the NUM_NONCES H0 result words back out over a valid/ready port. It sits between the host/FPGA harness and `bitcoin_hash`, replacing the behavioural SRAM model in hardware builds.

## Interface
Parameters:
- NUM_NONCES, 16: result words streamed after done (1..256).
- DEPTH, 2048: memory depth in 32-bit words.
- MSG_ADDR, 0: header base address, driven on message_addr.
- OUT_ADDR, 1000: result base address, driven on output_addr.

Ports:
- clk  in  1  sole clock; core's mem_clk must be tied to clk.
- reset  in  1  synchronous, active-high.
- seed  in  32  header seed, sampled with go.
- go  in  1  run request; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- start  out  1  to core start.
- message_addr  out  16  constant MSG_ADDR.
- output_addr  out  16  constant OUT_ADDR.
- done  in  1  from core.
- mem_we  in  1  core write enable.
- mem_addr  in  16  core word address.
- mem_write_data  in  32  core write data.
- mem_read_data  out  32  registered read data to core.
- res_valid  out  1  result beat valid.
- res_ready  in  1  sink ready.
- res_index  out  8  nonce index of current beat.
- res_data  out  32  H0 word for res_index.
- finished  out  1  one-cycle pulse after the last beat.
- cycles  out  32  run-length counter.
- oob_err  out  1  sticky out-of-range access flag.

## Operation
- States: IDLE -> FILL -> START -> RUN -> DRAIN -> IDLE.
- IDLE: go=1 latches seed and enters FILL.
- FILL: 19 cycles.
  - Cycle k writes mem[MSG_ADDR+k] = w_k.
  - w_0 = seed; w_k = rotl(w_{k-1}, 1).
  - Core port writes in FILL are ignored.
- START: start=1 for exactly 2 cycles, then RUN.
- RUN: core owns the memory port.
  - mem_we=1: mem[mem_addr] <= mem_write_data at the edge.
  - mem_we=0: mem_read_data <= mem[mem_addr] at the edge.
  - Leaves for DRAIN on the cycle done is sampled 1.
- DRAIN: internal reads of mem[OUT_ADDR+i] for i = 0..NUM_NONCES-1.
  - Each beat: res_valid, res_index=i, res_data; all held stable until res_ready=1.
  - After the last handshake: finished=1 for one cycle, then IDLE.
- The core port is also served in IDLE (for host preload and debug). In DRAIN, mem_read_data is undefined.
- Out of range (address >= DEPTH):
  - Write is dropped; read returns 0.
  - oob_err set; it is cleared only by reset.
- Address arithmetic is 16-bit. OUT_ADDR+NUM_NONCES-1 must be < DEPTH, checked at elaboration.

## Timing
- Reset values of outputs:
  - busy, start, res_valid, finished, oob_err, mem_read_data, res_index, res_data = 0.
  - cycles = 0.
  - message_addr and output_addr = constants.
- Reset in any state: returns to IDLE next edge, aborts any beat, leaves memory contents intact.
- go to first FILL write: 1 cycle (go sampled at edge N, first write at edge N+1). 19 writes, then 2 start cycles.
- Read latency: 1 cycle. Data for an address presented at edge N is visible after edge N.
- Write then read of the same address on consecutive cycles returns the new data.
- First res_valid: 2 cycles after done is sampled.
- Inter-beat timing: after each accepted beat res_valid is low for exactly 1 cycle, then the next beat appears.
- res_ready held high gives one beat per 2 cycles.
- go while busy is ignored. done outside RUN is ignored.

## Configuration
- BITCOIN_MEM_CYCLE_CNT_EN
  - Defined: cycles clears on entering START and increments every clk from the first START cycle through the cycle done is sampled, inclusive. It then holds until the next go.
  - Undefined: counter logic is absent and cycles is tied to 0.

## Test plan
- seed=0x01234567, go, core stubbed -> mem[0]=0x01234567, mem[1]=0x02468ACE, mem[18]=0x159C048D; start high for exactly 2 cycles.
- Core write 0xDEADBEEF to addr 5, then read addr 5 -> mem_read_data=0xDEADBEEF one cycle after the read edge.
- Preload mem[1000+i]=i+0x100, pulse done, res_ready=1 -> 16 beats with index 0..15 and data 0x100..0x10F; finished pulses once after beat 15.
- res_ready low for 5 cycles mid-drain -> beat data/index held stable; no beat lost or duplicated.
- Write to addr 2048 -> memory unchanged, read returns 0, oob_err=1 until reset.
- Reset asserted during RUN -> next edge busy=0, start=0, res_valid=0; mem[0] still 0x01234567; new go restarts FILL.

Source files
------------

// File: rtl/bitcoin_mem_responder.sv
// -----------------------------------------------------------------------------
// bitcoin_mem_responder
//
// Memory-side partner for the bitcoin_hash core. Owns a DEPTH x 32-bit word
// memory, writes the 19-word block header derived from a seed, pulses the
// core's start, serves the core's word-addressed memory port, and after the
// core reports done streams the NUM_NONCES H0 result words out over a
// valid/ready port.
//
// Sequence: IDLE -> FILL (19 header writes) -> START (start high 2 cycles)
//           -> RUN (core owns the memory) -> DRAIN (result beats) -> IDLE.
//
// Optional feature macro:
//   BITCOIN_MEM_CYCLE_CNT_EN - when defined, `cycles` counts clocks from the
//   first START cycle through the cycle done is sampled, then holds until
//   the next run. When undefined, the counter is absent and cycles reads 0.
//
// Ports:
//   clk            in   sole clock (core mem_clk must be tied to it)
//   reset          in   synchronous, active-high
//   seed    [31:0] in   header seed, captured with go
//   go             in   run request, honoured only in IDLE
//   busy           out  high in every state except IDLE
//   start          out  to core start
//   message_addr   out  constant MSG_ADDR
//   output_addr    out  constant OUT_ADDR
//   done           in   from core, honoured only in RUN
//   mem_we         in   core write enable
//   mem_addr[15:0] in   core word address
//   mem_write_data in   core write data
//   mem_read_data  out  registered read data to core (1-cycle latency)
//   res_valid      out  result beat valid
//   res_ready      in   result sink ready
//   res_index[7:0] out  nonce index of the current beat
//   res_data[31:0] out  H0 word for res_index
//   finished       out  one-cycle pulse after the last accepted beat
//   cycles  [31:0] out  run-length counter (see macro above)
//   oob_err        out  sticky out-of-range core access flag
// -----------------------------------------------------------------------------
module bitcoin_mem_responder #(
  parameter int NUM_NONCES = 16,
  parameter int DEPTH      = 2048,
  parameter int MSG_ADDR   = 0,
  parameter int OUT_ADDR   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seed,
  input  logic        go,
  output logic        busy,
  output logic        start,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_index,
  output logic [31:0] res_data,
  output logic        finished,
  output logic [31:0] cycles,
  output logic        oob_err
);

  localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_WORDS = 19;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (NUM_NONCES < 1 || NUM_NONCES > 256) begin : g_chk_num
    $error("bitcoin_mem_responder: NUM_NONCES must be in 1..256");
  end
  if (DEPTH < 1 || DEPTH > 65536) begin : g_chk_depth
    $error("bitcoin_mem_responder: DEPTH must be in 1..65536");
  end
  if (OUT_ADDR + NUM_NONCES - 1 >= DEPTH) begin : g_chk_out
    $error("bitcoin_mem_responder: result window exceeds DEPTH");
  end
  if (MSG_ADDR + FILL_WORDS - 1 >= DEPTH) begin : g_chk_msg
    $error("bitcoin_mem_responder: header window exceeds DEPTH");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_START,
    S_RUN,
    S_DRAIN
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [4:0]  fill_cnt_q, fill_cnt_d;
  logic [31:0] fill_word_q, fill_word_d;
  logic        start_cnt_q, start_cnt_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        drain_wait_q, drain_wait_d;   // one idle cycle before the first read
  logic        res_valid_q, res_valid_d;
  logic [7:0]  res_index_q, res_index_d;
  logic [31:0] res_data_q, res_data_d;
  logic        finished_q, finished_d;
  logic        oob_q, oob_d;
  logic [31:0] rd_q;

  logic [31:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Memory port steering
  // ---------------------------------------------------------------------------
  logic          core_served;
  logic          core_in_range;
  logic          core_wr;
  logic          core_rd;
  logic          fill_last;
  logic          last_beat;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic          rd_en;
  logic          rd_ok;
  logic [AW-1:0] rd_idx;

  always_comb begin
    // Reads are also taken in FILL; only writes are locked out there so the
    // header fill cannot be disturbed.
    core_served   = (state_q == S_IDLE) || (state_q == S_START) || (state_q == S_RUN);
    core_in_range = ({16'd0, mem_addr} < 32'(DEPTH));
    core_wr       = core_served && mem_we;
    core_rd       = (state_q != S_DRAIN) && !mem_we;
    fill_last     = (fill_cnt_q == 5'(FILL_WORDS - 1));
    last_beat     = (res_index_q == 8'(NUM_NONCES - 1));

    // Writes are suppressed during reset so that reset leaves memory intact.
    wr_en   = !reset && ((state_q == S_FILL) || (core_wr && core_in_range));
    wr_idx  = (state_q == S_FILL) ? (AW'(MSG_ADDR) + AW'(fill_cnt_q)) : mem_addr[AW-1:0];
    wr_data = (state_q == S_FILL) ? fill_word_q : mem_write_data;

    // DRAIN reads through the same port, addressed by the *next* index so the
    // word for the following beat is already in rd_q one cycle after a
    // handshake.
    rd_en  = (state_q == S_DRAIN) || core_rd;
    rd_ok  = (state_q == S_DRAIN) || core_in_range;
    rd_idx = (state_q == S_DRAIN) ? (AW'(OUT_ADDR) + AW'(res_index_d)) : mem_addr[AW-1:0];
  end

  // NOTE: the memory array has no reset; clearing thousands of words is not
  // something a RAM can do, and reset is required to preserve contents anyway.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= rd_ok ? mem[rd_idx] : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    fill_word_d  = fill_word_q;
    start_cnt_d  = start_cnt_q;
    start_d      = 1'b0;
    drain_wait_d = drain_wait_q;
    res_valid_d  = res_valid_q;
    res_index_d  = res_index_q;
    res_data_d   = res_data_q;
    finished_d   = 1'b0;
    oob_d        = oob_q | ((core_wr || core_rd) && !core_in_range);

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d     = S_FILL;
          fill_word_d = seed;
          fill_cnt_d  = '0;
        end
      end

      S_FILL: begin
        fill_word_d = {fill_word_q[30:0], fill_word_q[31]};
        fill_cnt_d  = fill_cnt_q + 5'd1;
        if (fill_last) begin
          state_d     = S_START;
          start_d     = 1'b1;
          start_cnt_d = 1'b0;
        end
      end

      S_START: begin
        if (start_cnt_q) begin
          state_d = S_RUN;
        end else begin
          start_cnt_d = 1'b1;
          start_d     = 1'b1;
        end
      end

      S_RUN: begin
        if (done) begin
          state_d      = S_DRAIN;
          drain_wait_d = 1'b1;
          res_valid_d  = 1'b0;
          res_index_d  = '0;
        end
      end

      S_DRAIN: begin
        if (finished_q) begin
          state_d = S_IDLE;
        end else if (drain_wait_q) begin
          drain_wait_d = 1'b0;
        end else if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_data_d  = rd_q;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          if (last_beat) begin
            finished_d = 1'b1;
          end else begin
            res_index_d = res_index_q + 8'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fill_cnt_q   <= '0;
      fill_word_q  <= '0;
      start_cnt_q  <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      drain_wait_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_index_q  <= '0;
      res_data_q   <= '0;
      finished_q   <= 1'b0;
      oob_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_word_q  <= fill_word_d;
      start_cnt_q  <= start_cnt_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      drain_wait_q <= drain_wait_d;
      res_valid_q  <= res_valid_d;
      res_index_q  <= res_index_d;
      res_data_q   <= res_data_d;
      finished_q   <= finished_d;
      oob_q        <= oob_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Run-length counter
  // ---------------------------------------------------------------------------
`ifdef BITCOIN_MEM_CYCLE_CNT_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if ((state_q == S_FILL) && fill_last) begin
      cycles_d = '0;
    end else if ((state_q == S_START) || (state_q == S_RUN)) begin
      // Includes the edge at which done is sampled in RUN.
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`else
  assign cycles = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy          = busy_q;
  assign start         = start_q;
  assign message_addr  = 16'(MSG_ADDR);
  assign output_addr   = 16'(OUT_ADDR);
  assign mem_read_data = rd_q;
  assign res_valid     = res_valid_q;
  assign res_index     = res_index_q;
  assign res_data      = res_data_q;
  assign finished      = finished_q;
  assign oob_err       = oob_q;

endmodule

// File: tb/tb_bitcoin_mem_responder.sv
// -----------------------------------------------------------------------------
// Testbench for bitcoin_mem_responder. The bench plays the role of the
// bitcoin_hash core (memory port + done) and of the result sink. Expected
// result beats are pushed into a scoreboard queue while the result window is
// preloaded and popped as the DUT hands beats over.
// -----------------------------------------------------------------------------
module tb_bitcoin_mem_responder;

  localparam int NN = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] seed;
  logic        go;
  logic        busy;
  logic        start;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        done;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_index;
  logic [31:0] res_data;
  logic        finished;
  logic [31:0] cycles;
  logic        oob_err;

  bitcoin_mem_responder #(
    .NUM_NONCES(NN),
    .DEPTH     (2048),
    .MSG_ADDR  (0),
    .OUT_ADDR  (1000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .seed          (seed),
    .go            (go),
    .busy          (busy),
    .start         (start),
    .message_addr  (message_addr),
    .output_addr   (output_addr),
    .done          (done),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_index     (res_index),
    .res_data      (res_data),
    .finished      (finished),
    .cycles        (cycles),
    .oob_err       (oob_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int cyc_start = 0;
  int cyc_done = 0;

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic core_write(input logic [15:0] a, input logic [31:0] d);
    mem_we = 1'b1;
    mem_addr = a;
    mem_write_data = d;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic core_read(input logic [15:0] a, output logic [31:0] d);
    mem_we = 1'b0;
    mem_addr = a;
    tick();
    d = mem_read_data;
  endtask

  function automatic int exp_cycles();
`ifdef BITCOIN_MEM_CYCLE_CNT_EN
    return cyc_done - cyc_start;
`else
    return 0;
`endif
  endfunction

  // Go, then wait until the two start cycles are over and the core owns memory.
  task automatic launch(input logic [31:0] s);
    seed = s;
    go = 1'b1;
    tick();
    go = 1'b0;
    seed = '0;
    repeat (22) tick();
  endtask

  // Collect result beats; stall_beat >= 0 drops res_ready for 5 cycles when
  // that beat first appears.
  task automatic drain_run(input int stall_beat);
    int    prev;
    int    beats;
    int    stall_left;
    int    fin_cnt;
    int    fin_t;
    int    last_t;
    bit    stalled;
    bit    accept;
    logic [7:0]  h_idx;
    logic [31:0] h_data;
    beat_t exp;
    prev = 0; beats = 0; stall_left = 0; fin_cnt = 0; fin_t = -1; last_t = -1;
    stalled = 1'b0; h_idx = '0; h_data = '0;
    res_ready = 1'b1;
    for (int t = 1; t <= 200; t++) begin
      tick();
      accept = 1'b0;
      if (finished === 1'b1) begin
        fin_cnt++;
        fin_t = t;
      end
      if (stall_left > 0) begin
        n_cmp++;
        if ({res_valid, res_index, res_data} !== {1'b1, h_idx, h_data}) begin
          n_err++;
          $display("FAIL stall_hold t=%0d: got v=%b idx=%0d data=%h, want v=1 idx=%0d data=%h",
                   t, res_valid, res_index, res_data, h_idx, h_data);
        end
        stall_left--;
        if (stall_left == 0) begin
          res_ready = 1'b1;
          accept = 1'b1;
        end
      end else if (res_valid === 1'b1) begin
        n_cmp++;
        if (t != prev + 2) begin
          n_err++;
          $display("FAIL beat_gap beat %0d: appeared at t=%0d, want t=%0d", beats, t, prev + 2);
        end
        if (beats == stall_beat && !stalled) begin
          stalled = 1'b1;
          stall_left = 5;
          res_ready = 1'b0;
          h_idx = res_index;
          h_data = res_data;
        end else begin
          accept = 1'b1;
        end
      end
      if (accept) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL extra_beat: idx=%0d data=%h, want no beat", res_index, res_data);
        end else begin
          exp = sb.pop_front();
          if ({res_index, res_data} !== {exp.idx, exp.data}) begin
            n_err++;
            $display("FAIL beat_data: got idx=%0d data=%h, want idx=%0d data=%h",
                     res_index, res_data, exp.idx, exp.data);
          end
        end
        beats++;
        prev = t;
        last_t = t;
      end
      if (fin_t >= 0 && t >= fin_t + 1) break;
    end
    n_cmp++;
    if (beats != NN || sb.size() != 0) begin
      n_err++;
      $display("FAIL beat_count: got %0d beats (%0d left), want %0d (0 left)", beats, sb.size(), NN);
    end
    n_cmp++;
    if (fin_cnt != 1 || fin_t != last_t + 1) begin
      n_err++;
      $display("FAIL finished_pulse: got %0d pulses at t=%0d, want 1 at t=%0d", fin_cnt, fin_t, last_t + 1);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_drain: busy=%b, want 0", busy);
    end
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({busy, start, res_valid, finished, oob_err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b, want 00000", {busy, start, res_valid, finished, oob_err});
    end
    n_cmp++;
    if (mem_read_data !== 32'h0 || res_data !== 32'h0 || res_index !== 8'h0) begin
      n_err++;
      $display("FAIL reset_data: rd=%h res_data=%h idx=%0d, want 0", mem_read_data, res_data, res_index);
    end
    n_cmp++;
    if (cycles !== 32'h0) begin
      n_err++;
      $display("FAIL reset_cycles: got %0d, want 0", cycles);
    end
    n_cmp++;
    if (message_addr !== 16'd0 || output_addr !== 16'd1000) begin
      n_err++;
      $display("FAIL reset_addrs: got %0d/%0d, want 0/1000", message_addr, output_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    int first;
    int hi;
    logic [31:0] d;
    first = -1;
    hi = 0;
    seed = 32'h0123_4567;
    go = 1'b1;
    tick();
    go = 1'b0;
    seed = '0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_after_go: got %b, want 1", busy);
    end
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (start === 1'b1) begin
        hi++;
        if (first < 0) begin
          first = k;
          cyc_start = cyc;
        end
      end
    end
    n_cmp++;
    if (hi != 2 || first != 19) begin
      n_err++;
      $display("FAIL start_pulse: got %0d cycles from cycle %0d, want 2 from 19", hi, first);
    end
    core_read(16'd0, d);
    n_cmp++;
    if (d !== 32'h0123_4567) begin
      n_err++;
      $display("FAIL fill_w0: got %h, want 01234567", d);
    end
    core_read(16'd1, d);
    n_cmp++;
    if (d !== 32'h0246_8ACE) begin
      n_err++;
      $display("FAIL fill_w1: got %h, want 02468ace", d);
    end
    core_read(16'd18, d);
    n_cmp++;
    if (d !== 32'h159C_048D) begin
      n_err++;
      $display("FAIL fill_w18: got %h, want 159c048d", d);
    end
  endtask

  task automatic test_rw();
    logic [31:0] d;
    bit bad;
    core_write(16'd5, 32'hDEAD_BEEF);
    core_read(16'd5, d);
    n_cmp++;
    if (d !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL rw_addr5: got %h, want deadbeef", d);
    end
    core_write(16'd6, 32'h1234_5678);
    core_read(16'd6, d);
    n_cmp++;
    if (d !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL rw_addr6: got %h, want 12345678", d);
    end
    core_read(16'd5, d);
    n_cmp++;
    if (d !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL rw_addr5_again: got %h, want deadbeef", d);
    end
    // go while busy must not restart the fill
    bad = 1'b0;
    seed = 32'hFFFF_0000;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (22) begin
      tick();
      if (start !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    core_read(16'd0, d);
    n_cmp++;
    if (bad || d !== 32'h0123_4567) begin
      n_err++;
      $display("FAIL go_while_busy: restart=%b mem0=%h, want 0/01234567", bad, d);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < NN; i++) begin
      core_write(16'(1000 + i), 32'h100 + 32'(i));
      sb.push_back({8'(i), 32'h100 + 32'(i)});
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    cyc_done = cyc;
    n_cmp++;
    if (cycles !== 32'(exp_cycles())) begin
      n_err++;
      $display("FAIL cycles_at_done: got %0d, want %0d", cycles, exp_cycles());
    end
    drain_run(-1);
    n_cmp++;
    if (cycles !== 32'(exp_cycles())) begin
      n_err++;
      $display("FAIL cycles_hold: got %0d, want %0d", cycles, exp_cycles());
    end
  endtask

  task automatic test_backpressure();
    launch(32'h0123_4567);
    n_cmp++;
    if (busy !== 1'b1 || start !== 1'b0) begin
      n_err++;
      $display("FAIL second_run: busy=%b start=%b, want 1/0", busy, start);
    end
    for (int i = 0; i < NN; i++) begin
      core_write(16'(1000 + i), 32'h5000_0000 + 32'(i * 3));
      sb.push_back({8'(i), 32'h5000_0000 + 32'(i * 3)});
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    drain_run(4);
  endtask

  task automatic test_oob();
    logic [31:0] d;
    bit bad;
    n_cmp++;
    if (oob_err !== 1'b0) begin
      n_err++;
      $display("FAIL oob_clear: got %b, want 0", oob_err);
    end
    // done outside RUN is ignored
    bad = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (4) begin
      tick();
      if (res_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL done_in_idle: got activity, want none");
    end
    core_write(16'd2048, 32'hCAFE_F00D);
    n_cmp++;
    if (oob_err !== 1'b1) begin
      n_err++;
      $display("FAIL oob_set: got %b, want 1", oob_err);
    end
    core_read(16'd2048, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL oob_read: got %h, want 0", d);
    end
    core_read(16'd0, d);
    n_cmp++;
    if (d !== 32'h0123_4567) begin
      n_err++;
      $display("FAIL oob_alias: mem0=%h, want 01234567", d);
    end
    repeat (3) tick();
    n_cmp++;
    if (oob_err !== 1'b1) begin
      n_err++;
      $display("FAIL oob_sticky: got %b, want 1", oob_err);
    end
  endtask

  task automatic test_reset_run();
    logic [31:0] d;
    launch(32'h0123_4567);
    core_write(16'd3, 32'hA5A5_A5A5);
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({busy, start, res_valid, oob_err} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_in_run: got %b, want 0000", {busy, start, res_valid, oob_err});
    end
    reset = 1'b0;
    core_read(16'd3, d);
    n_cmp++;
    if (d !== 32'hA5A5_A5A5) begin
      n_err++;
      $display("FAIL mem_kept3: got %h, want a5a5a5a5", d);
    end
    core_read(16'd0, d);
    n_cmp++;
    if (d !== 32'h0123_4567) begin
      n_err++;
      $display("FAIL mem_kept0: got %h, want 01234567", d);
    end
    launch(32'h8000_0001);
    core_read(16'd0, d);
    n_cmp++;
    if (d !== 32'h8000_0001) begin
      n_err++;
      $display("FAIL refill_w0: got %h, want 80000001", d);
    end
    core_read(16'd1, d);
    n_cmp++;
    if (d !== 32'h0000_0003) begin
      n_err++;
      $display("FAIL refill_w1: got %h, want 00000003", d);
    end
  endtask

  initial begin
    reset = 1'b1;
    seed = '0;
    go = 1'b0;
    done = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_write_data = '0;
    res_ready = 1'b0;
    test_reset();
    test_fill();
    test_rw();
    test_drain();
    test_backpressure();
    test_oob();
    test_reset_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
